// File: rtl/reg_access_ctrl_if.sv
// Instruction handshake plus the read/write ports toward reg_file.
// The controller side uses the master modport; the environment
// (instruction source and reg_file) uses the slave modport.
interface reg_access_ctrl_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  OUT1;
    logic [7:0]  OUT2;
    logic [2:0]  OUT1addr;
    logic [2:0]  OUT2addr;
    logic [2:0]  INaddr;
    logic [7:0]  IN;
    logic        WE;
    logic        done;
    logic        illegal;

    modport master (
        input  instr, instr_valid, OUT1, OUT2,
        output instr_ready, OUT1addr, OUT2addr, INaddr, IN, WE, done, illegal
    );

    modport slave (
        output instr, instr_valid, OUT1, OUT2,
        input  instr_ready, OUT1addr, OUT2addr, INaddr, IN, WE, done, illegal
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// Register-file access controller: accepts one instruction at a time,
// reads its operands from reg_file, runs an 8-bit ALU op and writes back.
//
// state | meaning
// IDLE  | ready for an instruction; illegal opcodes are rejected here
// RD1   | read addresses presented, reg_file registers the read data
// RD2   | read data valid, operands captured on leaving this state
// EX    | result computed, write port loaded on leaving this state
// WB    | WE high, reg_file writes on the negedge of this cycle
module reg_access_ctrl (
    input  logic                clk,
    input  logic                RESET,
    reg_access_ctrl_if.master   bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    logic [2:0] state;
    logic [7:0] opcode;
    logic [2:0] dest;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [7:0] result;

    logic [7:0] op_in;
    logic [2:0] dest_in;
    logic [2:0] src1_in;
    logic [2:0] src2_in;
    logic [7:0] imm_in;
    logic       legal_in;
    logic       unused_instr_bits;

    assign op_in    = bus.instr[31:24];
    assign dest_in  = bus.instr[18:16];
    assign src1_in  = bus.instr[10:8];
    assign src2_in  = bus.instr[2:0];
    assign imm_in   = bus.instr[7:0];
    assign legal_in = (op_in <= OP_OR);

    // Fields outside opcode/dest/src1/imm carry no meaning.
    assign unused_instr_bits = ^{bus.instr[23:19], bus.instr[15:11]};

    // Ready is gated by reset so it drops the moment reset is asserted.
    assign bus.instr_ready = (state == S_IDLE) && RESET;

    // 8-bit ALU; all arithmetic wraps modulo 256.
    always_comb begin
        result = 8'h00;
        case (opcode)
            OP_MOV:  result = opb;
            OP_ADD:  result = opa + opb;
            OP_SUB:  result = opa - opb;
            OP_AND:  result = opa & opb;
            OP_OR:   result = opa | opb;
            default: result = 8'h00;
        endcase
    end

    // Sequencer and registered outputs; done/illegal are single-cycle pulses.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state        <= S_IDLE;
            opcode       <= 8'h00;
            dest         <= 3'd0;
            opa          <= 8'h00;
            opb          <= 8'h00;
            bus.OUT1addr <= 3'd0;
            bus.OUT2addr <= 3'd0;
            bus.INaddr   <= 3'd0;
            bus.IN       <= 8'h00;
            bus.WE       <= 1'b0;
            bus.done     <= 1'b0;
            bus.illegal  <= 1'b0;
        end else begin
            bus.done    <= 1'b0;
            bus.illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        if (!legal_in) begin
                            bus.illegal <= 1'b1;
                        end else begin
                            opcode <= op_in;
                            dest   <= dest_in;
                            if (op_in == OP_LOADI) begin
                                bus.IN     <= imm_in;
                                bus.INaddr <= dest_in;
                                bus.WE     <= 1'b1;
                                state      <= S_WB;
                            end else begin
                                bus.OUT1addr <= src1_in;
                                bus.OUT2addr <= src2_in;
                                state        <= S_RD1;
                            end
                        end
                    end
                end
                S_RD1: state <= S_RD2;
                S_RD2: begin
                    opa   <= bus.OUT1;
                    opb   <= bus.OUT2;
                    state <= S_EX;
                end
                S_EX: begin
                    bus.IN     <= result;
                    bus.INaddr <= dest;
                    bus.WE     <= 1'b1;
                    state      <= S_WB;
                end
                S_WB: begin
                    bus.WE   <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    bus.WE <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/reg_access_ctrl.md
# reg_access_ctrl

Register-file access controller for the 8-bit single-cycle processor. It sits on the initiator side of `reg_file`: it accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it. It drives the two read addresses, captures the registered read data, and executes a small 8-bit ALU operation. It then drives the write port (address, data, write enable) back into `reg_file`.

## Interface
- No parameters. Widths are fixed: data 8 bits, register address 3 bits, instruction 32 bits.
- `clk`  in  1  single clock; all state changes on posedge.
- `RESET`  in  1  asynchronous, active-low reset (asserted when 0).
- `instr`  in  32  instruction fields:
  - opcode [31:24]
  - dest [18:16]
  - src1 [10:8]
  - src2 [2:0], or imm [7:0]
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  controller can accept; high only in IDLE with RESET deasserted.
- `OUT1`, `OUT2`  in  8  read data from `reg_file`, registered there on posedge.
- `OUT1addr`, `OUT2addr`  out  3  read addresses to `reg_file`.
- `INaddr`  out  3  write address.
- `IN`  out  8  write data.
- `WE`  out  1  write enable; `reg_file` writes on the negedge inside a `WE`=1 cycle.
- `done`  out  1  one-cycle pulse after a completed writeback.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- Opcodes:
  - 0x00 LOADI: dest ← imm
  - 0x01 MOV: dest ← R[src2]
  - 0x02 ADD: dest ← R[src1]+R[src2]
  - 0x03 SUB: dest ← R[src1]−R[src2]
  - 0x04 AND
  - 0x05 OR
  - any other value: illegal
- Arithmetic is modulo 2^8. No carry or overflow output; SUB is two's complement wrap.
- FSM states: IDLE, RD1, RD2, EX, WB.
- IDLE with instr_valid=1 at a posedge: instruction accepted, opcode/dest/imm latched, then:
  - LOADI → WB, with IN=imm and INaddr=dest registered at the same edge.
  - MOV and ALU ops → RD1, with OUT1addr=src1 and OUT2addr=src2 registered. MOV still drives both addresses.
  - Illegal → stays in IDLE; illegal=1 for the next cycle; no write.
- RD1 → RD2 unconditionally. `reg_file` latches the read data at this edge.
- RD2 → EX. OUT1 and OUT2 are captured into internal operands A and B at this edge.
- EX → WB. IN=result and INaddr=dest are registered; WE=1 from this edge.
- WB → IDLE. WE returns to 0 and done=1 for one cycle.
- Outputs are registered and held between updates:
  - OUT1addr and OUT2addr hold their last value outside RD1/RD2.
  - IN and INaddr hold after WB.
- No overlap: a new instruction is accepted only in IDLE. instr_valid held high across completion is accepted at the first posedge in IDLE.

## Timing
- Accept edge E0. For register ops:
  - read addresses valid after E0
  - operands captured at E2
  - WE high from E3 to E4
  - done high from E4 to E5
- LOADI: WE high from E0 to E1; done high from E1 to E2.
- Illegal: illegal high from E0 to E1; instr_ready stays 1, so the next instruction can be accepted at E1.
- Throughput: one register op per 5 cycles; one LOADI per 2 cycles.
- Reset values are forced immediately on RESET=0, independent of clk:
  - state IDLE
  - OUT1addr, OUT2addr, INaddr = 0
  - IN = 0x00
  - WE, done, illegal = 0
  - instr_ready = 0 while RESET=0
- Reset mid-operation abandons the instruction. If asserted during WB, WE drops at once and no write may occur at the following negedge.
- Release of RESET takes effect at the first posedge with RESET=1. instr_ready goes to 1 in that cycle.

## Test plan
Bench pairs the block with a `reg_file` model preloaded with R[i]=i.
- LOADI 0x000500FF:
  - accepted at E0
  - WE=1 with INaddr=5 and IN=0xFF during cycle E0–E1
  - done during E1–E2
  - R5 reads back 0xFF
- ADD 0x02030102:
  - OUT1addr=1 and OUT2addr=2 after E0
  - WE=1, INaddr=3, IN=0x03 during E3–E4
  - done during E4–E5
- SUB 0x03040102: IN=0xFF (wrap) written to R4; AND 0x04060506 writes 0x04 to R6; OR 0x04 vs 0x05 variants check logic ops.
- Illegal opcode 0x07 followed back-to-back by MOV 0x01070003:
  - illegal pulses for one cycle with WE=0
  - MOV accepted at E1
  - R7=0x03 written 4 cycles later
- Handshake: instr_valid held high across two ADDs. instr_ready=0 during RD1..WB; the second instruction is accepted exactly at the edge leaving WB+1 (IDLE). No instruction is dropped or duplicated.
- Reset:
  - RESET=0 mid-cycle during WB: WE=0 immediately; target register keeps its old value; all outputs at reset values.
  - After release, LOADI completes normally.
